ddr3_dma_read_client: RTL and testbench

- Upstream requester and downstream data sink for one client port of the 16-port DDR3 DMA read engine.
- Accepts a 2-D read descriptor: base address, row count, row length, and row stride, all in 64-byte units.
- Issues one DMA read request per row and captures the 512-bit beats tagged for this client into a local buffer.
- Presents the beats to the compute pipeline on a valid/ready stream.
- Space-based credit guarantees the buffer can never overflow, because the DMA data path has no per-client backpressure.

---
 rtl/ddr3_dma_read_client.sv | 234 +++++++++++++++++++++++
 tb/tb_ddr3_dma_read_client.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dma_read_client.sv
// One client port of the DDR3 DMA read engine: walks a 2-D descriptor row by row,
// captures the returned beats into a local FWFT buffer and streams them out.
module ddr3_dma_read_client #(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned BUF_DEPTH = 512,
    parameter int unsigned ROWS_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic [ROWS_W-1:0] desc_rows,
    input  logic [ADDR_W-1:0] desc_row_len,
    input  logic [ADDR_W-1:0] desc_stride,
    output logic              desc_err,
    output logic              done,
    output logic              busy,
    output logic              read_req,
    output logic [ADDR_W-1:0] read_start_addr,
    output logic [ADDR_W-1:0] read_length,
    input  logic              read_ack,
    input  logic [DATA_W-1:0] dma_data,
    input  logic              dma_en,
    input  logic              dma_eop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow
);

    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = DATA_W + 1;
    localparam int unsigned FREE_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DRAIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   row_len_q;
    logic [ADDR_W-1:0]   stride_q;
    logic [ROWS_W-1:0]   rows_q;
    logic [ROWS_W-1:0]   issue_idx_q;
    logic [ROWS_W-1:0]   rows_done_q;
    logic [FREE_W-1:0]   free_cnt_q;
    logic                desc_ready_q;
    logic                desc_err_q;
    logic                done_q;
    logic                busy_q;
    logic                read_req_q;
    logic [ADDR_W-1:0]   read_start_addr_q;
    logic [ADDR_W-1:0]   read_length_q;
    logic                overflow_q;

    // Buffer: one output staging register in front of a circular memory.
    logic [ENT_W-1:0]    mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    mcnt_q, mcnt_d;
    logic [ENT_W-1:0]    out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                mem_we;

    logic                ack;
    logic                pop;
    logic                full;
    logic                wr_en;
    logic                drop;
    logic                last_tag;
    logic                desc_bad;
    logic [ENT_W-1:0]    in_ent;

    assign desc_ready      = desc_ready_q;
    assign desc_err        = desc_err_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign read_req        = read_req_q;
    assign read_start_addr = read_start_addr_q;
    assign read_length     = read_length_q;
    assign out_data        = out_q[DATA_W-1:0];
    assign out_last        = out_q[DATA_W];
    assign out_valid       = out_valid_q;
    assign overflow        = overflow_q;

    // Handshake qualifiers and descriptor legality.
    always_comb begin
        ack      = read_ack & read_req_q;
        pop      = out_valid_q & out_ready;
        full     = (mcnt_q + CNT_W'(out_valid_q)) == CNT_W'(BUF_DEPTH);
        wr_en    = dma_en & ~(full & ~pop);
        drop     = dma_en & full & ~pop;
        last_tag = dma_eop & (rows_done_q == (rows_q - ROWS_W'(1)));
        in_ent   = {last_tag, dma_data};
        desc_bad = (desc_rows == ROWS_W'(0)) ||
                   (desc_row_len < ADDR_W'(2)) ||
                   (desc_row_len > ADDR_W'(BUF_DEPTH));
    end

    // Buffer next-state: refill the staging register whenever it empties or pops.
    always_comb begin
        mem_we      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mcnt_d      = mcnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (pop || !out_valid_q) begin
            if (mcnt_q != CNT_W'(0)) begin
                out_d       = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                if (wr_en) begin
                    mem_we = 1'b1;
                end else begin
                    mcnt_d = mcnt_q - CNT_W'(1);
                end
            end else if (wr_en) begin
                out_d       = in_ent;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (wr_en) begin
            mem_we = 1'b1;
            mcnt_d = mcnt_q + CNT_W'(1);
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mcnt_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mcnt_q      <= mcnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Control FSM, request registers and space-based credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            row_len_q         <= '0;
            stride_q          <= '0;
            rows_q            <= '0;
            issue_idx_q       <= '0;
            rows_done_q       <= '0;
            free_cnt_q        <= FREE_W'(BUF_DEPTH);
            desc_ready_q      <= 1'b0;
            desc_err_q        <= 1'b0;
            done_q            <= 1'b0;
            busy_q            <= 1'b0;
            read_req_q        <= 1'b0;
            read_start_addr_q <= '0;
            read_length_q     <= '0;
        end else begin
            desc_err_q <= 1'b0;
            done_q     <= 1'b0;
            free_cnt_q <= free_cnt_q - (ack ? {1'b0, row_len_q} : FREE_W'(0)) + FREE_W'(pop);
            if (dma_en && dma_eop) begin
                rows_done_q <= rows_done_q + ROWS_W'(1);
            end
            case (state_q)
                IDLE: begin
                    desc_ready_q <= 1'b1;
                    if (desc_valid && desc_ready_q) begin
                        if (desc_bad) begin
                            desc_err_q <= 1'b1;
                        end else begin
                            addr_q       <= desc_base;
                            row_len_q    <= desc_row_len;
                            stride_q     <= desc_stride;
                            rows_q       <= desc_rows;
                            issue_idx_q  <= '0;
                            rows_done_q  <= '0;
                            desc_ready_q <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (free_cnt_q >= {1'b0, row_len_q}) begin
                        read_req_q        <= 1'b1;
                        read_start_addr_q <= addr_q;
                        read_length_q     <= row_len_q;
                        state_q           <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack) begin
                        read_req_q  <= 1'b0;
                        addr_q      <= addr_q + stride_q;
                        issue_idx_q <= issue_idx_q + ROWS_W'(1);
                        state_q     <= ((issue_idx_q + ROWS_W'(1)) == rows_q) ? DRAIN : ISSUE;
                    end
                end
                DRAIN: begin
                    if (pop && out_q[DATA_W]) begin
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        desc_ready_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_dma_read_client.sv
// Scoreboard bench for ddr3_dma_read_client: a DMA responder checks requests and
// queues expected beats, a monitor pops and compares every accepted output beat.
module tb_ddr3_dma_read_client;

    localparam int unsigned ADDR_W    = 27;
    localparam int unsigned DATA_W    = 512;
    localparam int unsigned BUF_DEPTH = 8;
    localparam int unsigned ROWS_W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_base;
    logic [ROWS_W-1:0] desc_rows;
    logic [ADDR_W-1:0] desc_row_len;
    logic [ADDR_W-1:0] desc_stride;
    logic              desc_err;
    logic              done;
    logic              busy;
    logic              read_req;
    logic [ADDR_W-1:0] read_start_addr;
    logic [ADDR_W-1:0] read_length;
    logic              read_ack;
    logic [DATA_W-1:0] dma_data;
    logic              dma_en;
    logic              dma_eop;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              overflow;

    ddr3_dma_read_client #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .ROWS_W(ROWS_W)
    ) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_base(desc_base),
        .desc_rows(desc_rows), .desc_row_len(desc_row_len), .desc_stride(desc_stride),
        .desc_err(desc_err), .done(done), .busy(busy),
        .read_req(read_req), .read_start_addr(read_start_addr), .read_length(read_length),
        .read_ack(read_ack), .dma_data(dma_data), .dma_en(dma_en), .dma_eop(dma_eop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] addr; logic [ADDR_W-1:0] len; bit fin; int dly; } req_t;
    typedef struct { logic eop; logic last; logic [DATA_W-1:0] data; } send_t;
    typedef struct { logic last; logic [DATA_W-1:0] data; } beat_t;

    req_t  exp_req[$];
    send_t beat_q[$];
    beat_t sb[$];

    int checks   = 0;
    int errors   = 0;
    int req_cnt  = 0;
    int done_cnt = 0;
    bit kill     = 1'b0;

    function automatic logic [DATA_W-1:0] mkdata(input logic [ADDR_W-1:0] a, input int i);
        logic [31:0] w;
        w = {a[15:0], 16'(i)};
        return {16{w}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l,
                            input bit f, input int d);
        req_t r;
        r.addr = a; r.len = l; r.fin = f; r.dly = d;
        exp_req.push_back(r);
    endtask

    task automatic submit(input logic [ADDR_W-1:0] b, input logic [ROWS_W-1:0] r,
                          input logic [ADDR_W-1:0] l, input logic [ADDR_W-1:0] s);
        desc_base = b; desc_rows = r; desc_row_len = l; desc_stride = s;
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        int start;
        int cyc;
        start = done_cnt;
        cyc = 0;
        while (done_cnt == start && cyc < 3000) begin
            if (toggle) out_ready = ((cyc % 4) != 2) && ((cyc % 7) != 3);
            step();
            cyc++;
        end
        out_ready = 1'b1;
        if (cyc >= 3000) begin
            errors++;
            $display("FAIL done_timeout act=%0d exp=%0d", done_cnt - start, 1);
        end
        repeat (4) step();
        chk("done_once", 64'(done_cnt - start), 64'd1);
    endtask

    task automatic finish_test(input string nm);
        repeat (3) step();
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({nm, "_req_empty"}, 64'(exp_req.size()), 64'd0);
        chk({nm, "_overflow"}, 64'(overflow), 64'd0);
        chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic pop_one();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk("pop_one_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // DMA responder: grants requests after a per-row delay, then streams the row.
    initial begin
        req_t  cur;
        send_t s;
        bit    active;
        bit    ack_given;
        int    dly;
        active = 1'b0; ack_given = 1'b0; dly = 0;
        read_ack = 1'b0; dma_en = 1'b0; dma_eop = 1'b0; dma_data = '0;
        forever begin
            step();
            read_ack = 1'b0; dma_en = 1'b0; dma_eop = 1'b0;
            if (rst || kill) begin
                beat_q.delete();
                active = 1'b0;
                ack_given = 1'b0;
                continue;
            end
            if (ack_given) begin
                ack_given = 1'b0;
                chk("req_drop_after_ack", 64'(read_req), 64'd0);
            end
            if (beat_q.size() > 0) begin
                beat_t e;
                s = beat_q.pop_front();
                dma_en = 1'b1; dma_eop = s.eop; dma_data = s.data;
                e.last = s.last; e.data = s.data;
                sb.push_back(e);
            end
            if (read_req && !active) begin
                active = 1'b1;
                req_cnt++;
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected act=%0h exp=none", read_start_addr);
                    cur.addr = read_start_addr; cur.len = '0; cur.fin = 1'b0; cur.dly = 0;
                end else begin
                    cur = exp_req.pop_front();
                    if (read_start_addr !== cur.addr) begin
                        errors++;
                        $display("FAIL req_addr act=%0h exp=%0h", read_start_addr, cur.addr);
                    end
                    chk("req_len", 64'(read_length), 64'(cur.len));
                end
                dly = cur.dly;
            end else if (active) begin
                if (dly == 0) begin
                    read_ack = 1'b1;
                    active = 1'b0;
                    ack_given = 1'b1;
                    for (int i = 0; i < int'(cur.len); i++) begin
                        s.eop  = (i == int'(cur.len) - 1);
                        s.last = cur.fin && s.eop;
                        s.data = mkdata(cur.addr, i);
                        beat_q.push_back(s);
                    end
                end else begin
                    dly--;
                end
            end
        end
    end

    // Output monitor: every accepted beat must match the scoreboard head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected act=%0b/%h exp=none", out_last, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        errors++;
                        $display("FAIL beat act=%0b/%h exp=%0b/%h", out_last, out_data, e.last, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; desc_valid = 1'b0; out_ready = 1'b0;
        desc_base = '0; desc_rows = '0; desc_row_len = '0; desc_stride = '0;
        repeat (3) step();
        chk("rst_desc_ready", 64'(desc_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_read_req", 64'(read_req), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_addr_len", 64'({read_start_addr, read_length}), 64'd0);
        chk("rst_pulses", 64'({done, desc_err, out_last}), 64'd0);
        rst = 1'b0;
        step();
        chk("desc_ready_after_rst", 64'(desc_ready), 64'd1);

        // one row
        out_ready = 1'b1;
        push_req(27'h100, 27'd4, 1'b1, 2);
        submit(27'h100, 16'd1, 27'd4, 27'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_desc_ready", 64'(desc_ready), 64'd0);
        chk("t1_desc_err", 64'(desc_err), 64'd0);
        chk("t1_req_not_yet", 64'(read_req), 64'd0);
        step();
        chk("t1_req_earliest", 64'(read_req), 64'd1);
        wait_done(1'b0);
        finish_test("t1");

        // three rows, stride 0x40
        push_req(27'h10, 27'd2, 1'b0, 1);
        push_req(27'h50, 27'd2, 1'b0, 3);
        push_req(27'h90, 27'd2, 1'b1, 0);
        submit(27'h10, 16'd3, 27'd2, 27'h40);
        wait_done(1'b0);
        finish_test("t2");

        // credit stall: second row must wait for four pops
        out_ready = 1'b0;
        base = req_cnt;
        push_req(27'h1000, 27'd6, 1'b0, 1);
        push_req(27'h1006, 27'd6, 1'b1, 1);
        submit(27'h1000, 16'd2, 27'd6, 27'd6);
        repeat (30) step();
        chk("t3_stall_hold", 64'(req_cnt - base), 64'd1);
        repeat (3) pop_one();
        repeat (10) step();
        chk("t3_stall_after3", 64'(req_cnt - base), 64'd1);
        pop_one();
        repeat (3) step();
        chk("t3_release_after4", 64'(req_cnt - base), 64'd2);
        out_ready = 1'b1;
        wait_done(1'b0);
        finish_test("t3");

        // backpressure over four full-buffer rows
        push_req(27'h200, 27'd8, 1'b0, 0);
        push_req(27'h208, 27'd8, 1'b0, 1);
        push_req(27'h210, 27'd8, 1'b0, 2);
        push_req(27'h218, 27'd8, 1'b1, 3);
        submit(27'h200, 16'd4, 27'd8, 27'd8);
        wait_done(1'b1);
        finish_test("t4");

        // illegal descriptors
        base = req_cnt;
        submit(27'h0, 16'd0, 27'd4, 27'd0);
        chk("t5_rows0_err", 64'({desc_err, busy, read_req}), 64'b100);
        step();
        chk("t5_rows0_pulse", 64'(desc_err), 64'd0);
        submit(27'h0, 16'd1, 27'd1, 27'd0);
        chk("t5_len1_err", 64'({desc_err, busy, read_req}), 64'b100);
        step();
        chk("t5_len1_pulse", 64'(desc_err), 64'd0);
        submit(27'h0, 16'd1, 27'(BUF_DEPTH + 1), 27'd0);
        chk("t5_lenbig_err", 64'({desc_err, busy, read_req}), 64'b100);
        step();
        chk("t5_lenbig_pulse", 64'({desc_err, busy, desc_ready}), 64'b001);
        repeat (5) step();
        chk("t5_no_req", 64'(req_cnt - base), 64'd0);

        // reset while waiting for the second grant with 3 beats buffered
        out_ready = 1'b0;
        base = req_cnt;
        push_req(27'h300, 27'd3, 1'b0, 1);
        push_req(27'h310, 27'd3, 1'b1, 500);
        submit(27'h300, 16'd2, 27'd3, 27'h10);
        for (int n = 0; n < 100 && (req_cnt - base) < 2; n++) step();
        chk("t6_second_req", 64'(req_cnt - base), 64'd2);
        repeat (8) step();
        chk("t6_buffered", 64'({out_valid, read_req}), 64'b11);
        rst = 1'b1; kill = 1'b1;
        step();
        chk("t6_rst_req", 64'(read_req), 64'd0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_busy", 64'({busy, desc_ready}), 64'd0);
        step();
        rst = 1'b0; kill = 1'b0;
        sb.delete();
        exp_req.delete();
        step();
        chk("t6_ready_again", 64'(desc_ready), 64'd1);
        out_ready = 1'b1;
        push_req(27'h400, 27'd8, 1'b1, 2);
        submit(27'h400, 16'd1, 27'd8, 27'd0);
        step();
        chk("t6_full_credit_req", 64'(read_req), 64'd1);
        wait_done(1'b0);
        finish_test("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
